// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through fetch, decode, exec,
// optional mem and write, with a per-stage watchdog and halts taken only between instructions.
module core_sequencer #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        run,
   input  logic        halt_req,
   output logic        fetch_enable,
   output logic        decode_enable,
   output logic        exec_enable,
   output logic        mem_enable,
   output logic        write_enable,
   input  logic        fetch_done,
   input  logic        decode_done,
   input  logic        exec_done,
   input  logic        mem_done,
   input  logic        write_done,
   input  logic        decode_is_mem,
   input  logic        decode_is_halt,
   output logic        busy,
   output logic        halted,
   output logic        error,
   output logic [2:0]  err_stage,
   output logic [31:0] instr_count
);

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExec, StMem, StWrite, StHalted, StError
   } state_e;

   state_e      state_q, state_d;
   logic        is_mem_q, is_halt_q, halt_pend_q;
   logic [15:0] wd_cnt_q;
   logic        in_stage, cur_done, cur_enable, stage_done, wd_fire;
   logic [2:0]  cur_code;

   always_comb begin
      in_stage   = 1'b1;
      cur_done   = 1'b0;
      cur_enable = 1'b0;
      cur_code   = 3'd0;
      case (state_q)
         StFetch:  begin cur_done = fetch_done;  cur_enable = fetch_enable;  cur_code = 3'd1; end
         StDecode: begin cur_done = decode_done; cur_enable = decode_enable; cur_code = 3'd2; end
         StExec:   begin cur_done = exec_done;   cur_enable = exec_enable;   cur_code = 3'd3; end
         StMem:    begin cur_done = mem_done;    cur_enable = mem_enable;    cur_code = 3'd4; end
         StWrite:  begin cur_done = write_done;  cur_enable = write_enable;  cur_code = 3'd5; end
         default:  in_stage = 1'b0;
      endcase
   end

   // A done coinciding with its own enable pulse cannot answer that request yet.
   assign stage_done = cur_done && !cur_enable;
   assign wd_fire    = (TIMEOUT != 0) && in_stage && !stage_done && (32'(wd_cnt_q) == TIMEOUT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (halt_req)  state_d = StHalted;
            else if (run)  state_d = StFetch;
         end
         StFetch:  if (stage_done) state_d = StDecode;
         StDecode: if (stage_done) state_d = StExec;
         StExec:   if (stage_done) state_d = is_mem_q ? StMem : StWrite;
         StMem:    if (stage_done) state_d = StWrite;
         StWrite: begin
            if (stage_done) begin
               if (is_halt_q || halt_pend_q || halt_req) state_d = StHalted;
               else if (run)                             state_d = StFetch;
               else                                      state_d = StIdle;
            end
         end
         default: state_d = state_q;
      endcase
      if (wd_fire) state_d = StError;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= StIdle;
         fetch_enable  <= 1'b0;
         decode_enable <= 1'b0;
         exec_enable   <= 1'b0;
         mem_enable    <= 1'b0;
         write_enable  <= 1'b0;
         busy          <= 1'b0;
         halted        <= 1'b0;
         error         <= 1'b0;
         err_stage     <= 3'd0;
         instr_count   <= 32'd0;
         wd_cnt_q      <= 16'd0;
         is_mem_q      <= 1'b0;
         is_halt_q     <= 1'b0;
         halt_pend_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_enable  <= (state_d == StFetch)  && (state_q != StFetch);
         decode_enable <= (state_d == StDecode) && (state_q != StDecode);
         exec_enable   <= (state_d == StExec)   && (state_q != StExec);
         mem_enable    <= (state_d == StMem)    && (state_q != StMem);
         write_enable  <= (state_d == StWrite)  && (state_q != StWrite);
         busy          <= state_d inside {StFetch, StDecode, StExec, StMem, StWrite};
         halted        <= (state_d == StHalted);
         error         <= (state_d == StError);
         if (wd_fire) err_stage <= cur_code;

         // Every state change into a stage coincides with its enable pulse.
         if (state_d != state_q) wd_cnt_q <= 16'd0;
         else if (in_stage)      wd_cnt_q <= wd_cnt_q + 16'd1;

         if (state_q == StDecode && stage_done) begin
            is_mem_q  <= decode_is_mem;
            is_halt_q <= decode_is_halt;
         end
         if (state_q == StWrite && stage_done) instr_count <= instr_count + 32'd1;

         if (state_d == StHalted)       halt_pend_q <= 1'b0;
         else if (in_stage && halt_req) halt_pend_q <= 1'b1;
      end
   end

endmodule
